// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit: registered multi-operand forwarding selects, load-use stall FSM and stall counter
module forward_hazard_unit #(
  parameter int REG_ADDR_W        = 5,
  parameter int NUM_SRC           = 2,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic [REG_ADDR_W-1:0]         ex_rd,
  input  logic                          ex_reg_write,
  input  logic                          ex_mem_read,
  input  logic [REG_ADDR_W-1:0]         exmem_rd,
  input  logic                          exmem_reg_write,
  output logic [NUM_SRC*2-1:0]          forward_sel,
  output logic                          stall,
  output logic [CNT_W-1:0]              stall_count
);
  typedef enum logic {IDLE, STALL} state_t;
  state_t state, state_nx;
  logic [2:0] rem, rem_nx;
  logic [NUM_SRC-1:0] hit_ex, hit_exmem, hit_load;
  logic [NUM_SRC*2-1:0] sel_nx;
  logic detect;
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [REG_ADDR_W-1:0] src;
    logic live;
    assign src = id_src[k*REG_ADDR_W +: REG_ADDR_W];
    assign live = id_valid & id_src_used[k] & (src != '0);
    assign hit_ex[k] = live & ex_reg_write & (src == ex_rd);
    assign hit_exmem[k] = live & exmem_reg_write & (src == exmem_rd);
    assign hit_load[k] = hit_ex[k] & ex_mem_read;
    // the EX producer is younger than EX/MEM, so it wins
    assign sel_nx[2*k +: 2] = hit_ex[k] ? 2'b10 : hit_exmem[k] ? 2'b01 : 2'b00;
  end
  assign detect = |hit_load;
  always_comb begin
    state_nx = state;
    rem_nx = rem;
    stall = ~reset & ~flush & ((state == STALL) | detect);
    if (flush) begin
      state_nx = IDLE;
      rem_nx = '0;
    end else if (state == STALL) begin
      rem_nx = rem - 3'd1;
      state_nx = (rem == 3'd1) ? IDLE : STALL;
    end else if (detect && LOAD_STALL_CYCLES > 1) begin
      state_nx = STALL;
      rem_nx = 3'(LOAD_STALL_CYCLES - 1);
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      rem <= '0;
      forward_sel <= '0;
      stall_count <= '0;
    end else begin
      state <= state_nx;
      rem <= rem_nx;
      // a stalled or flushed ID sends a bubble into EX, which needs no forwarding
      forward_sel <= (flush | stall) ? '0 : sel_nx;
      if (stall && !(&stall_count)) stall_count <= stall_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_forward_hazard_unit.sv
// tb_forward_hazard_unit: scoreboard bench comparing two configurations against a cycle-level reference model
module tb_forward_hazard_unit;
  localparam int RW = 5;
  localparam int NS = 2;
  logic clock = 0, reset = 1, flush = 0, id_valid = 0;
  logic [NS*RW-1:0] id_src = '0;
  logic [NS-1:0] id_src_used = '0;
  logic [RW-1:0] ex_rd = '0, exmem_rd = '0;
  logic ex_reg_write = 0, ex_mem_read = 0, exmem_reg_write = 0;
  logic [3:0] fs1, fs3;
  logic st1, st3;
  logic [1:0] sc1;
  logic [15:0] sc3;
  always #5 clock = ~clock;

  forward_hazard_unit #(.REG_ADDR_W(RW), .NUM_SRC(NS), .LOAD_STALL_CYCLES(1), .CNT_W(2)) dut1 (
    .clock(clock), .reset(reset), .flush(flush), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .forward_sel(fs1), .stall(st1),
    .stall_count(sc1));
  forward_hazard_unit #(.REG_ADDR_W(RW), .NUM_SRC(NS), .LOAD_STALL_CYCLES(3), .CNT_W(16)) dut3 (
    .clock(clock), .reset(reset), .flush(flush), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .forward_sel(fs3), .stall(st3),
    .stall_count(sc3));

  typedef struct {
    logic s1, s3;
    logic [3:0] f1, f3;
    int c1, c3;
  } exp_t;
  exp_t q[$];
  int n_checks = 0, n_fail = 0;
  int left[2] = '{0, 0};
  int cnt[2] = '{0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [1:0] ref_sel(input int k);
    logic [RW-1:0] s;
    s = id_src[k*RW +: RW];
    if (!id_valid || !id_src_used[k] || s == 0) return 2'b00;
    if (ex_reg_write && s == ex_rd) return 2'b10;
    if (exmem_reg_write && s == exmem_rd) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit hazard();
    for (int k = 0; k < NS; k++)
      if (ref_sel(k) == 2'b10 && ex_mem_read) return 1;
    return 0;
  endfunction

  // left[i] = extra stall cycles still owed by the current hazard
  task automatic model(input int i, input bit d, input logic [3:0] f,
                       output logic s, output logic [3:0] fo, output int c);
    int len, mx;
    len = (i == 0) ? 1 : 3;
    mx = (i == 0) ? 3 : 65535;
    s = !flush && (left[i] > 0 || d);
    if (flush) left[i] = 0;
    else if (left[i] > 0) left[i]--;
    else if (d) left[i] = len - 1;
    if (s && cnt[i] < mx) cnt[i]++;
    fo = (flush || s) ? 4'b0 : f;
    c = cnt[i];
  endtask

  task automatic tick();
    exp_t e;
    bit d;
    logic [3:0] f;
    d = hazard();
    f = {ref_sel(1), ref_sel(0)};
    model(0, d, f, e.s1, e.f1, e.c1);
    model(1, d, f, e.s3, e.f3, e.c3);
    q.push_back(e);
    @(posedge clock);
    #2;
  endtask

  task automatic set_in(input logic v, input int s1, input int s0, input logic [1:0] used,
                        input int erd, input logic erw, input logic emr, input int mrd, input logic mrw);
    id_valid = v;
    id_src = {RW'(s1), RW'(s0)};
    id_src_used = used;
    ex_rd = RW'(erd);
    ex_reg_write = erw;
    ex_mem_read = emr;
    exmem_rd = RW'(mrd);
    exmem_reg_write = mrw;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall_L1", 32'(st1), 32'(e.s1));
        chk("stall_L3", 32'(st3), 32'(e.s3));
        @(posedge clock);
        #1;
        chk("fsel_L1", 32'(fs1), 32'(e.f1));
        chk("fsel_L3", 32'(fs3), 32'(e.f3));
        chk("count_L1", 32'(sc1), e.c1);
        chk("count_L3", 32'(sc3), e.c3);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    set_in(1, 2, 1, 2'b11, 1, 1, 1, 0, 0);
    repeat (2) @(posedge clock);
    #2;
    chk("reset_stall_L1", 32'(st1), 0);
    chk("reset_stall_L3", 32'(st3), 0);
    chk("reset_fsel", 32'({fs1, fs3}), 0);
    chk("reset_count", 32'({sc1, sc3}), 0);
    reset = 0;
    set_in(1, 2, 1, 2'b11, 1, 1, 0, 0, 0); tick();
    set_in(1, 2, 3, 2'b11, 3, 1, 0, 3, 1); tick();
    set_in(1, 2, 3, 2'b11, 3, 0, 0, 3, 1); tick();
    set_in(1, 0, 0, 2'b11, 0, 1, 1, 0, 1); tick();
    set_in(1, 4, 1, 2'b11, 4, 1, 1, 0, 0); tick();
    set_in(1, 4, 1, 2'b11, 0, 0, 0, 4, 1);
    repeat (4) tick();
    set_in(1, 5, 2, 2'b11, 5, 1, 1, 0, 0); tick();
    flush = 1; tick();
    flush = 0;
    set_in(1, 5, 2, 2'b11, 0, 0, 0, 5, 1);
    repeat (2) tick();
    set_in(1, 6, 2, 2'b10, 6, 1, 1, 0, 0); tick();
    #1;
    reset = 1;
    #1;
    chk("async_stall_L1", 32'(st1), 0);
    chk("async_stall_L3", 32'(st3), 0);
    chk("async_fsel", 32'({fs1, fs3}), 0);
    chk("async_count", 32'({sc1, sc3}), 0);
    left = '{0, 0};
    cnt = '{0, 0};
    @(posedge clock);
    #2;
    reset = 0;
    set_in(1, 7, 1, 2'b10, 7, 1, 1, 0, 0);
    repeat (5) tick();
    for (int n = 0; n < 400; n++) begin
      flush = ($urandom_range(15) == 0);
      set_in($urandom_range(7) != 0, $urandom_range(3), $urandom_range(3), 2'($urandom_range(3)),
             $urandom_range(3), 1'($urandom_range(1)), $urandom_range(2) == 0,
             $urandom_range(3), 1'($urandom_range(1)));
      tick();
    end
    flush = 0;
    repeat (3) @(posedge clock);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
